alu_mult_sequencer: RTL and testbench

- Multi-cycle controller that computes a 32x32 unsigned multiply (low 32 bits of the product) using only the shared 32-bit ALU's ADD, SLL and SRL operations.
- The block owns the ALU control inputs (operation, A, B, shamt) while busy and samples ALUResult/Zero each cycle.
- Sits beside the ALU in the execute stage; the core starts it with a one-cycle pulse and waits for done.

---
 rtl/alu_mult_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_mult_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Shift-add multiplier sequencer that borrows the shared execute-stage ALU.
// Produces the low 32 bits of multiplicand * multiplier using only ADD, SLL and SRL.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ALU released (AND of zeros); waiting for a start pulse
// ADD    | acc + mc on the ALU; result kept only when mq[0] is set
// SHL    | mc << 1 on the ALU
// SHR    | mq >> 1 on the ALU; Zero or the iteration cap ends the loop
// DONE   | product captured, one-cycle done pulse; start ignored
module alu_mult_sequencer #(
  parameter int         MAX_ITER = 32,
  parameter logic [3:0] OP_AND   = 4'b0000,
  parameter logic [3:0] OP_ADD   = 4'b0011,
  parameter logic [3:0] OP_SLL   = 4'b0101,
  parameter logic [3:0] OP_SRL   = 4'b0110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int ITER_W = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        mc_q, mc_d;
  logic [31:0]        mq_q, mq_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [31:0]        product_q, product_d;

  // Next-state, datapath updates and ALU drive; ALU inputs depend only on state and registers.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mc_d      = mc_q;
    mq_d      = mq_q;
    iter_d    = iter_q;
    product_d = product_q;
    alu_op    = OP_AND;
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_shamt = 5'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = 32'd0;
          mc_d    = multiplicand;
          mq_d    = multiplier;
          iter_d  = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        alu_op = OP_ADD;
        alu_a  = acc_q;
        alu_b  = mc_q;
        if (mq_q[0]) acc_d = alu_result;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_op    = OP_SLL;
        alu_a     = mc_q;
        alu_shamt = 5'd1;
        mc_d      = alu_result;
        state_d   = S_SHR;
      end
      S_SHR: begin
        alu_op    = OP_SRL;
        alu_a     = mq_q;
        alu_shamt = 5'd1;
        mq_d      = alu_result;
        // Zero means no multiplier bits remain, so further iterations would add nothing.
        if (alu_zero || (iter_q == ITER_LAST)) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= 32'd0;
      mc_q      <= 32'd0;
      mq_q      <= 32'd0;
      iter_q    <= '0;
      product_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      mq_q      <= mq_d;
      iter_q    <= iter_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_ADD) || (state_q == S_SHL) || (state_q == S_SHR);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: a simple ALU model closes the loop, and an
// operation-level model (product = M*Q, length = 3 cycles per multiplier bit)
// predicts every output on every cycle.
module tb_alu_mult_sequencer;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  alu_mult_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_shamt    (alu_shamt),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Shared ALU behaviour.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SLL:  alu_result = alu_a << alu_shamt;
      OP_SRL:  alu_result = alu_a >> alu_shamt;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int niter(input logic [31:0] q);
    int n = 1;
    for (int i = 0; i < 32; i++) if (q[i]) n = i + 1;
    return n;
  endfunction

  // Operation-level reference model.
  int          m_rem   = 0;
  int          m_total = 0;
  bit          m_done  = 1'b0;
  logic [31:0] m_prod  = 32'd0;
  logic [31:0] m_m     = 32'd0;
  logic [31:0] m_q     = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_prod = 32'd0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_prod = m_m * m_q;
      end
    end else if (start) begin
      m_m     = multiplicand;
      m_q     = multiplier;
      m_total = 3 * niter(multiplier);
      m_rem   = m_total;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    #1;
    if (checking) begin
      logic [3:0]  e_op;
      logic [31:0] e_a, e_b;
      logic [4:0]  e_sh;
      logic [63:0] mask;
      int idx, k;
      e_op = OP_AND; e_a = 32'd0; e_b = 32'd0; e_sh = 5'd0;
      if (m_rem > 0) begin
        idx  = m_total - m_rem;
        k    = idx / 3;
        mask = (64'd1 << k) - 64'd1;
        case (idx % 3)
          0: begin e_op = OP_ADD; e_a = m_m * (m_q & mask[31:0]); e_b = m_m << k; end
          1: begin e_op = OP_SLL; e_a = m_m << k; e_sh = 5'd1; end
          default: begin e_op = OP_SRL; e_a = m_q >> k; e_sh = 5'd1; end
        endcase
      end
      chk("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("product", product, m_prod);
      chk("alu_op", {28'd0, alu_op}, {28'd0, e_op});
      chk("alu_a", alu_a, e_a);
      chk("alu_b", alu_b, e_b);
      chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, e_sh});
    end
  end

  // One operation: start pulse sampled at E0, optional extra start at E(restart_at),
  // optional reset at E(abort_at); pinned runs check literal product and latency.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int restart_at,
                        input int abort_at, input bit pin, input logic [31:0] exp_p,
                        input int exp_lat);
    int k;
    bit hit;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    k   = 0;
    hit = 1'b0;
    forever begin
      @(negedge clk);
      if (abort_at > 0 && k == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_alu_op", {28'd0, alu_op}, {28'd0, OP_AND});
        chk("abort_alu_a", alu_a, 32'd0);
        return;
      end
      if (done) begin
        hit = 1'b1;
        break;
      end
      if (k >= 200) break;
      start = (k + 1 == restart_at);
      if (start) begin
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      reset = (abort_at > 0) && (k + 1 == abort_at);
      @(posedge clk);
      k++;
    end
    start = 1'b0;
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 200 cycles for M=0x%08h Q=0x%08h", m, q);
    end else if (pin) begin
      chk("latency", k, exp_lat);
      chk("pinned_product", product, exp_p);
      chk("model_product", m_prod, exp_p);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;
    @(posedge clk);
    checking = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);

    run_op(32'd3, 32'd5, 0, 0, 1'b1, 32'd15, 9);
    run_op(32'h12345678, 32'd0, 0, 0, 1'b1, 32'd0, 3);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b1, 32'h00000001, 96);
    run_op(32'h00010000, 32'h00010000, 0, 0, 1'b1, 32'd0, 51);
    run_op(32'd7, 32'd6, 5, 0, 1'b1, 32'd42, 9);
    run_op(32'd9, 32'd10, 0, 0, 1'b1, 32'd90, 12);
    run_op(32'd5, 32'd9, 0, 4, 1'b0, 32'd0, 0);
    run_op(32'd2, 32'd3, 0, 0, 1'b1, 32'd6, 6);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] rm, rq;
      int ra;
      rm = $urandom;
      rq = $urandom >> $urandom_range(0, 31);
      ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(rm, rq, ra, 0, 1'b0, 32'd0, 0);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
